// File: rtl/ddr_ex_pkg.sv
// Shared types and default constants for the DDR example pattern controller.
package ddr_ex_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StFinish
    } state_e;

    localparam int unsigned DefaultSeed     = 32;
    localparam int unsigned DefaultNumWords = 16;

endpackage

// File: rtl/nios_ddr_sdram_ex_lfsr8.sv
// 8-bit LFSR (x^8+x^4+x^3+x^2+1); held at SEED while enable is low, steps when pause is low.
module nios_ddr_sdram_ex_lfsr8 #(
    parameter int unsigned SEED = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       pause,
    input  logic       load,
    input  logic [7:0] ldata,
    output logic [7:0] data
);

    localparam logic [7:0] SeedByte = 8'(SEED);

    logic [7:0] data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= SeedByte;
        end else if (!enable) begin
            data_q <= SeedByte;
        end else if (load) begin
            data_q <= ldata;
        end else if (!pause) begin
            data_q <= {data_q[6:4], data_q[3:1] ^ {3{data_q[7]}}, data_q[0], data_q[7]};
        end
    end

    assign data = data_q;

endmodule

// File: rtl/ddr_ex_pattern_ctrl.sv
// Memory pattern tester: writes an LFSR sequence over NUM_WORDS words, reads it back and
// counts mismatches against a second LFSR running in lock-step with returned data.
module ddr_ex_pattern_ctrl
    import ddr_ex_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned NUM_WORDS = DefaultNumWords,
    parameter int unsigned SEED      = DefaultSeed
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic [AW-1:0] m_address,
    output logic          m_write,
    output logic [7:0]    m_writedata,
    output logic          m_read,
    input  logic          m_waitrequest,
    input  logic [7:0]    m_readdata,
    input  logic          m_readdatavalid,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_count,
    output logic [AW-1:0] first_err_addr
);

    // One extra bit so a full 2^AW pass can be counted.
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LastIdx   = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] NumWordsC = CW'(NUM_WORDS);

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] ret_q, ret_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [AW-1:0] first_err_q, first_err_d;
    logic          pass_q, pass_d;

    logic [7:0] gen_data;
    logic [7:0] chk_data;
    logic       lfsr_en;
    logic       wr_acc;
    logic       rd_acc;
    logic       rdv_acc;
    logic       mismatch;

    assign lfsr_en  = (state_q != StIdle);
    assign wr_acc   = (state_q == StWrite) && !m_waitrequest;
    assign rd_acc   = (state_q == StRead) && !m_waitrequest;
    assign rdv_acc  = m_readdatavalid && ((state_q == StRead) || (state_q == StDrain));
    assign mismatch = rdv_acc && (m_readdata != chk_data);

    nios_ddr_sdram_ex_lfsr8 #(
        .SEED (SEED)
    ) u_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (lfsr_en),
        .pause   (!wr_acc),
        .load    (1'b0),
        .ldata   (8'h00),
        .data    (gen_data)
    );

    nios_ddr_sdram_ex_lfsr8 #(
        .SEED (SEED)
    ) u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (lfsr_en),
        .pause   (!rdv_acc),
        .load    (1'b0),
        .ldata   (8'h00),
        .data    (chk_data)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        idx_d       = idx_q;
        ret_d       = ret_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;

        if (rdv_acc) begin
            ret_d = ret_q + CW'(1);
            if (mismatch) begin
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
                if (err_count_q == 8'd0) begin
                    first_err_d = base_q + ret_q[AW-1:0];
                end
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StWrite;
                    base_d      = base_addr;
                    idx_d       = '0;
                    ret_d       = '0;
                    err_count_d = '0;
                end
            end
            StWrite: begin
                if (wr_acc) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StRead;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            StRead: begin
                if (rd_acc) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StDrain;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            StDrain: begin
                if (ret_d == NumWordsC) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                // err_count_q already includes a mismatch on the last returned word.
                pass_d  = (err_count_q == 8'd0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            idx_q       <= '0;
            ret_q       <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            ret_q       <= ret_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    // Address and data only move on accept, so both stay stable under waitrequest.
    assign m_address      = base_q + idx_q[AW-1:0];
    assign m_writedata    = gen_data;
    assign m_write        = (state_q == StWrite);
    assign m_read         = (state_q == StRead);
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StFinish);
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_ddr_ex_pattern_ctrl.sv
// Randomised bench: slave memory model plus a count-based reference of the pattern test.
module tb_ddr_ex_pattern_ctrl;

    localparam int unsigned NW     = 16;
    localparam int unsigned BIG_NW = 300;
    localparam int unsigned SEED   = 32;

    typedef struct {
        logic [7:0] d;
        int         due;
    } rsp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic [7:0] m_address;
    logic       m_write;
    logic [7:0] m_writedata;
    logic       m_read;
    logic       m_waitrequest = 1'b0;
    logic [7:0] m_readdata = 8'h00;
    logic       m_readdatavalid = 1'b0;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] first_err_addr;

    logic       b_start = 1'b0;
    logic [8:0] b_base = 9'h000;
    logic [8:0] b_address;
    logic       b_write;
    logic [7:0] b_writedata;
    logic       b_read;
    logic       b_waitrequest = 1'b0;
    logic [7:0] b_readdata = 8'h00;
    logic       b_readdatavalid = 1'b0;
    logic       b_busy;
    logic       b_done;
    logic       b_pass;
    logic [7:0] b_err_count;
    logic [8:0] b_first_err_addr;

    ddr_ex_pattern_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .m_address       (m_address),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_addr  (first_err_addr)
    );

    ddr_ex_pattern_ctrl #(
        .AW        (9),
        .NUM_WORDS (BIG_NW)
    ) dut_big (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (b_start),
        .base_addr       (b_base),
        .m_address       (b_address),
        .m_write         (b_write),
        .m_writedata     (b_writedata),
        .m_read          (b_read),
        .m_waitrequest   (b_waitrequest),
        .m_readdata      (b_readdata),
        .m_readdatavalid (b_readdatavalid),
        .busy            (b_busy),
        .done            (b_done),
        .pass            (b_pass),
        .err_count       (b_err_count),
        .first_err_addr  (b_first_err_addr)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model state
    logic [7:0] expv [BIG_NW];
    bit         active = 1'b0;
    int         wr_cnt = 0, rd_cnt = 0, ret_cnt = 0, errs = 0, done_cnt = 0;
    logic [7:0] base_m = 8'h00;
    logic [7:0] first_exp = 8'h00;
    bit         pass_exp = 1'b0;
    logic       exp_w, exp_r, exp_done;
    logic [7:0] exp_a;

    // Slave state
    logic [7:0] mem [256];
    rsp_t       rq[$];
    rsp_t       rsp;
    logic [7:0] rd_d;
    int         wait_pct = 0, lat_min = 0, lat_max = 0;
    bit         corrupt_one = 1'b0, corrupt_all = 1'b0;
    logic [7:0] corrupt_addr = 8'h13;
    int         n_wr = 0, n_rd = 0;
    logic [7:0] wlog_a[$];
    logic [7:0] wlog_d[$];
    bit         prev_stall = 1'b0;
    logic       prev_w, prev_r;
    logic [7:0] prev_a, prev_d;
    bit         start_req = 1'b0;

    // Large-pass model
    bit         b_start_req = 1'b0;
    bit         b_active = 1'b0;
    int         b_rets = 0, b_done_cnt = 0;
    logic       b_pend = 1'b0;
    logic       b_exp_done;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle slave, model update and comparison, all at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                active = 1'b0; wr_cnt = 0; rd_cnt = 0; ret_cnt = 0; errs = 0;
                first_exp = 8'h00; pass_exp = 1'b0; prev_stall = 1'b0;
                b_active = 1'b0; b_rets = 0; b_pend = 1'b0; b_readdatavalid = 1'b0;
                start = 1'b0; b_start = 1'b0; m_readdatavalid = 1'b0;
                check("rst_m_write", m_write, 0);
                check("rst_m_read", m_read, 0);
                check("rst_m_address", m_address, 0);
                check("rst_m_writedata", m_writedata, SEED);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_pass", pass, 0);
                check("rst_err_count", err_count, 0);
                check("rst_first_err", first_err_addr, 0);
            end else begin
                exp_w    = active && (wr_cnt < NW);
                exp_r    = active && (wr_cnt == NW) && (rd_cnt < NW);
                exp_done = active && (ret_cnt == NW);
                check("busy", busy, active);
                check("done", done, exp_done);
                check("m_write", m_write, exp_w);
                check("m_read", m_read, exp_r);
                check("excl", m_write & m_read, 0);
                if (exp_w) begin
                    exp_a = base_m + 8'(wr_cnt);
                    check("wr_addr", m_address, exp_a);
                    check("wr_data", m_writedata, expv[wr_cnt]);
                end
                if (exp_r) begin
                    exp_a = base_m + 8'(rd_cnt);
                    check("rd_addr", m_address, exp_a);
                end
                check("err_count", err_count, (errs > 255) ? 255 : errs);
                check("first_err", first_err_addr, first_exp);
                check("pass", pass, pass_exp);
                if (prev_stall) begin
                    check("stall_w", m_write, prev_w);
                    check("stall_r", m_read, prev_r);
                    check("stall_addr", m_address, prev_a);
                    if (prev_w) check("stall_data", m_writedata, prev_d);
                end

                start     = start_req;
                start_req = 1'b0;
                m_waitrequest   = ($urandom_range(99) < wait_pct);
                m_readdatavalid = 1'b0;
                m_readdata      = 8'($urandom);
                if (rq.size() > 0 && rq[0].due <= cyc) begin
                    rsp = rq.pop_front();
                    m_readdatavalid = 1'b1;
                    m_readdata      = rsp.d;
                end
                prev_stall = (m_write || m_read) && m_waitrequest;
                prev_w = m_write; prev_r = m_read; prev_a = m_address; prev_d = m_writedata;

                if (m_write && !m_waitrequest) begin
                    mem[m_address] = m_writedata;
                    wlog_a.push_back(m_address);
                    wlog_d.push_back(m_writedata);
                    n_wr++;
                end
                if (m_read && !m_waitrequest) begin
                    rd_d = mem[m_address];
                    if (corrupt_all) rd_d = ~rd_d;
                    else if (corrupt_one && m_address == corrupt_addr) rd_d = rd_d ^ 8'h01;
                    rq.push_back('{d: rd_d, due: cyc + 1 + lat_min + int'($urandom_range(lat_max, 0))});
                    n_rd++;
                end

                if (start && !active) begin
                    active = 1'b1; wr_cnt = 0; rd_cnt = 0; ret_cnt = 0; errs = 0;
                    base_m = base_addr; n_wr = 0; n_rd = 0;
                    wlog_a.delete(); wlog_d.delete();
                end else if (active) begin
                    if (exp_done) begin
                        active   = 1'b0;
                        pass_exp = (errs == 0);
                        done_cnt++;
                    end else begin
                        if (m_readdatavalid && wr_cnt == NW && ret_cnt < NW) begin
                            if (m_readdata != expv[ret_cnt]) begin
                                if (errs == 0) first_exp = base_m + 8'(ret_cnt);
                                errs++;
                            end
                            ret_cnt++;
                        end
                        if (exp_w && !m_waitrequest) wr_cnt++;
                        else if (exp_r && !m_waitrequest) rd_cnt++;
                    end
                end

                // Large pass: zero-wait slave that always returns 0x00 (never an LFSR value).
                b_exp_done = b_active && (b_rets == BIG_NW);
                check("b_done", b_done, b_exp_done);
                check("b_err_count", b_err_count, (b_rets > 255) ? 255 : b_rets);
                check("b_excl", b_write & b_read, 0);
                b_start         = b_start_req;
                b_start_req     = 1'b0;
                b_readdatavalid = b_pend;
                b_pend          = b_read;
                if (b_start && !b_active) begin
                    b_active = 1'b1;
                    b_rets   = 0;
                end else if (b_active) begin
                    if (b_exp_done) begin
                        b_active = 1'b0;
                        b_done_cnt++;
                    end else if (b_readdatavalid) begin
                        b_rets++;
                    end
                end
            end
        end
    end

    task automatic run_pass(input logic [7:0] base, input int extra);
        int d0;
        int t;
        d0 = done_cnt;
        t  = 0;
        @(posedge clk);
        #1;
        base_addr = base;
        start_req = 1'b1;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
            if (extra != 0 && t == extra) start_req = 1'b1;
        end
        check("pass_completed", (done_cnt != d0), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        expv[0] = 8'(SEED);
        for (int i = 1; i < BIG_NW; i++) expv[i] = lfsr_next(expv[i-1]);

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        // Zero-wait clean pass
        run_pass(8'h10, 0);
        check("clean_pass", pass, 1);
        check("clean_err", err_count, 0);
        check("w0_data", wlog_d[0], 8'h20);
        check("w1_data", wlog_d[1], 8'h40);
        check("w3_data", wlog_d[3], 8'h1D);
        check("w0_addr", wlog_a[0], 8'h10);
        check("w15_addr", wlog_a[15], 8'h1F);
        check("clean_n_wr", n_wr, 16);
        check("clean_n_rd", n_rd, 16);

        // Single corrupted word at 0x13
        corrupt_one = 1'b1;
        run_pass(8'h10, 0);
        corrupt_one = 1'b0;
        check("corrupt_pass", pass, 0);
        check("corrupt_err", err_count, 1);
        check("corrupt_first", first_err_addr, 8'h13);

        // Random stalls and read latency
        wait_pct = 50; lat_max = 7;
        run_pass(8'h40, 0);
        check("stall_pass", pass, 1);
        check("stall_n_wr", n_wr, 16);
        check("stall_n_rd", n_rd, 16);

        // Address wrap
        wait_pct = 30; lat_max = 3;
        run_pass(8'hF8, 0);
        check("wrap_pass", pass, 1);
        check("wrap_a0", wlog_a[0], 8'hF8);
        check("wrap_a7", wlog_a[7], 8'hFF);
        check("wrap_a8", wlog_a[8], 8'h00);
        check("wrap_a15", wlog_a[15], 8'h07);

        // Reset with three reads outstanding; late data is wrong so any use would show.
        wait_pct = 0; lat_min = 7; lat_max = 0; corrupt_all = 1'b1;
        @(posedge clk);
        #1;
        base_addr = 8'h50;
        start_req = 1'b1;
        t = 0;
        while (!(active && rd_cnt >= 3) && t < 500) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("outstanding", rq.size(), 3);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        t = 0;
        while (rq.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_err", err_count, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_pass", pass, 0);
        corrupt_all = 1'b0; lat_min = 0; lat_max = 3;
        run_pass(8'h20, 0);
        check("post_rst_clean", pass, 1);

        // Every word wrong, with a start pulse while busy
        corrupt_all = 1'b1; wait_pct = 20;
        run_pass(8'h00, 5);
        corrupt_all = 1'b0;
        check("allbad_err", err_count, 16);
        check("allbad_pass", pass, 0);
        check("allbad_first", first_err_addr, 8'h00);
        check("allbad_n_wr", n_wr, 16);

        // 300-word pass: error count saturates
        begin
            int d0;
            d0 = b_done_cnt;
            @(posedge clk);
            #1;
            b_start_req = 1'b1;
            t = 0;
            while (b_done_cnt == d0 && t < 3000) begin
                @(posedge clk);
                t++;
            end
            check("big_completed", (b_done_cnt != d0), 1);
            repeat (2) @(posedge clk);
            #1;
            check("big_err", b_err_count, 255);
            check("big_pass", b_pass, 0);
            check("big_first", b_first_err_addr, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, %0d tests so far", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
